// File: rtl/efi_spi_pkg.sv
// Shared definitions for the efi SPI initiator.
//   spi_state_e : frame sequencer states
//   CPOL/CPHA   : SPI mode constants (mode 0: sck idles low, data launched before first rising edge)
//   clog2       : ceil(log2(value)) for sizing counters from parameters
package efi_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/efi_spi_half_timer.sv
// sck half-period timer.
//   clk, reset_n : clock, async active-low reset
//   enable       : count while high; the count is held at zero while low, so every
//                  enable rising edge starts a fresh full half-period
//   tick         : one-cycle pulse every CLK_DIV enabled cycles
module efi_spi_half_timer
    import efi_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/efi_spi_master.sv
// SPI initiator, mode 0, MSB first. One word per start; cs stays low between words
// of a frame until a word tagged last completes.
//   clk, reset_n      : clock, async active-low reset
//   start/tx_data/last: word request, accepted when ready=1
//   ready, busy       : handshake / frame-in-progress
//   rx_data, rx_valid : received word and its one-cycle strobe
//   sck, mosi, cs     : SPI bus outputs (all registered)
//   miso              : SPI bus input, asynchronous
module efi_spi_master
    import efi_spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              last,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs
);

    localparam int BIT_W  = clog2(DATA_W + 1);
    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = clog2(PH_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [PH_W-1:0]  SETUP_END = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_END  = PH_W'(CS_HOLD - 1);

    spi_state_e        state_q, state_d;
    logic              miso_meta, miso_sync;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic              last_q;
    logic              tick;
    logic              accept;
    logic              sck_fall;
    logic              word_done;

    efi_spi_half_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_half_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_q == SHIFT),
        .tick    (tick)
    );

    assign ready      = (state_q == IDLE) || (state_q == WAIT);
    assign busy       = (state_q != IDLE);
    assign accept     = start && ready;
    assign sck_fall   = tick && (sck != CPOL);
    assign word_done  = sck_fall && (bit_cnt == LAST_BIT);
    assign shreg_next = {shreg[DATA_W-2:0], miso_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (ph_cnt == SETUP_END) state_d = SHIFT;
            SHIFT:   if (word_done) state_d = last_q ? HOLD : WAIT;
            WAIT:    if (start) state_d = SHIFT;
            HOLD:    if (ph_cnt == HOLD_END) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The shift register carries the not-yet-sent tx bits above the received bits:
    // mosi is launched from its MSB on each falling edge while miso enters at the
    // LSB, so after DATA_W falling edges it holds exactly the received word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ph_cnt    <= '0;
            last_q    <= 1'b0;
            sck       <= CPOL;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
            rx_valid  <= 1'b0;
            cs        <= (state_d == IDLE) || (state_d == GAP);

            if ((state_d != state_q) || !((state_q == SETUP) || (state_q == HOLD))) begin
                ph_cnt <= '0;
            end else begin
                ph_cnt <= ph_cnt + 1'b1;
            end

            if (accept) begin
                // First bit is on the wire before the first rising edge.
                mosi    <= (CPHA == 1'b0) ? tx_data[DATA_W-1] : 1'b0;
                shreg   <= {tx_data[DATA_W-2:0], 1'b0};
                last_q  <= last;
                bit_cnt <= '0;
            end

            if (tick) begin
                sck <= ~sck;
                if (sck_fall) begin
                    shreg   <= shreg_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (word_done) begin
                        // mosi keeps the final bit through WAIT/HOLD.
                        rx_data  <= shreg_next;
                        rx_valid <= 1'b1;
                    end else begin
                        mosi <= shreg[DATA_W-1];
                    end
                end
            end

            if (state_d == IDLE) mosi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_efi_spi_master.sv
module tb_efi_spi_master;

    localparam int DW       = 16;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int FRAME_CS = CS_SETUP + 2 * CLK_DIV * DW + CS_HOLD;  // 68
    localparam int LAT_IDLE = 1 + CS_SETUP + CLK_DIV;  // start -> first sck high (negedges)
    localparam int LAT_WAIT = 1 + CLK_DIV;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] tx_data;
    logic          last;
    logic          ready;
    logic          busy;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          sck;
    logic          mosi;
    logic          miso;
    logic          cs;

    efi_spi_master #(
        .DATA_W   (DW),
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .tx_data  (tx_data),
        .last     (last),
        .ready    (ready),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs       (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // miso source: 0 loopback, 1 tied low, 2 tied high, 3 register-file slave
    int miso_mode;

    // efi_main-style slave: command word's low nibble selects a register that is
    // returned in the following word of the same frame.
    logic [DW-1:0] slv_regs [16];
    logic [DW-1:0] s_in, s_out, s_next;
    int            s_bits;
    bit            s_load;
    logic          s_sck_q;

    initial begin
        s_in = '0; s_out = '0; s_next = '0; s_bits = 0; s_load = 0; s_sck_q = 1'b0;
    end

    always @(posedge sck or negedge sck or negedge cs) begin
        if (cs === 1'b0) begin
            if (sck && !s_sck_q) begin
                s_in = {s_in[DW-2:0], mosi};
                s_bits++;
                if (s_bits == DW) begin
                    s_bits = 0;
                    s_next = slv_regs[s_in[3:0]];
                    s_load = 1;
                end
            end else if (!sck && s_sck_q) begin
                if (s_load) begin
                    s_out  = s_next;
                    s_load = 0;
                end else begin
                    s_out = {s_out[DW-2:0], 1'b0};
                end
            end else begin
                s_bits = 0; s_out = '0; s_load = 0;
            end
        end
        s_sck_q = sck;
    end

    always_comb begin
        case (miso_mode)
            0:       miso = mosi;
            1:       miso = 1'b0;
            2:       miso = 1'b1;
            default: miso = s_out[DW-1];
        endcase
    end

    // Bus monitor, sampled 1 time unit after each rising clock edge.
    int            cs_low_cnt, cs_rise_cnt, sck_rise_cnt, rxv_cnt;
    logic [DW-1:0] bus_bits;
    logic          sck_prev, cs_prev;

    initial begin
        cs_low_cnt = 0; cs_rise_cnt = 0; sck_rise_cnt = 0; rxv_cnt = 0;
        bus_bits = '0; sck_prev = 1'b0; cs_prev = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (cs === 1'b0) cs_low_cnt++;
        if (cs === 1'b1 && cs_prev === 1'b0) cs_rise_cnt++;
        if (sck === 1'b1 && sck_prev === 1'b0) begin
            sck_rise_cnt++;
            bus_bits = {bus_bits[DW-2:0], mosi};
        end
        if (rx_valid === 1'b1) rxv_cnt++;
        sck_prev = sck;
        cs_prev  = cs;
    end

    int n_pass, n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        cs_low_cnt = 0; cs_rise_cnt = 0; sck_rise_cnt = 0; rxv_cnt = 0; bus_bits = '0;
    endtask

    // What a mode-0 master must receive for a word: loopback echoes, ties are constant.
    function automatic logic [DW-1:0] ref_rx(input logic [DW-1:0] tx, input int mode);
        case (mode)
            0:       return tx;
            1:       return '0;
            default: return '1;
        endcase
    endfunction

    // Called at a negedge with ready=1. Returns at the negedge where rx_valid is seen.
    task automatic send_word(input logic [DW-1:0] tx, input logic lst,
                             output logic [DW-1:0] rx, output int lat);
        int n;
        start = 1'b1; tx_data = tx; last = lst;
        @(negedge clk);
        start = 1'b0; tx_data = ~tx; last = ~lst;
        check("cs_low_after_start", cs, 0);
        lat = -1;
        rx  = 'x;
        for (n = 1; n < 400; n++) begin
            if (lat < 0 && sck === 1'b1) lat = n;
            if (rx_valid === 1'b1) begin
                rx = rx_data;
                break;
            end
            @(negedge clk);
        end
        check("rx_valid_seen", n < 400, 1);
    endtask

    task automatic wait_idle(output bit gap);
        gap = 0;
        for (int n = 0; n < 400; n++) begin
            if (busy === 1'b0) break;
            if (cs === 1'b1 && ready === 1'b0) gap = 1;
            @(negedge clk);
        end
        check("idle_reached", busy, 0);
        check("ready_when_idle", ready, 1);
    endtask

    task automatic run_frame(input logic [DW-1:0] tx, input int mode,
                             input logic [DW-1:0] exp, input string tag);
        logic [DW-1:0] rx;
        int            lat;
        bit            gap;
        miso_mode = mode;
        clear_mon();
        send_word(tx, 1'b1, rx, lat);
        check({tag, "_rx"}, rx, exp);
        check({tag, "_latency"}, lat, LAT_IDLE);
        wait_idle(gap);
        check({tag, "_cs_low_cycles"}, cs_low_cnt, FRAME_CS);
        check({tag, "_sck_rises"}, sck_rise_cnt, DW);
        check({tag, "_rx_valid_pulses"}, rxv_cnt, 1);
        check({tag, "_mosi_order"}, bus_bits, tx);
        check({tag, "_cs_high_gap"}, gap, 1);
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        int            mode;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rx;
        logic [DW-1:0] t;
        int            lat, m, n;
        bit            gap;

        n_pass = 0; n_total = 0;
        reset_n = 1'b0; start = 1'b0; tx_data = '0; last = 1'b0; miso_mode = 1;
        for (int i = 0; i < 16; i++) slv_regs[i] = DW'(i * 16'h0101);
        slv_regs[5] = 16'h5EED;

        vecs[0] = '{16'hA55A, 0, 16'hA55A};
        vecs[1] = '{16'h1234, 2, 16'hFFFF};
        vecs[2] = '{16'hABCD, 1, 16'h0000};
        vecs[3] = '{16'h8001, 0, 16'h8001};
        vecs[4] = '{16'h0001, 0, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sck", sck, 0);
        check("rst_cs", cs, 1);
        check("rst_mosi", mosi, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single-word frames
        foreach (vecs[i]) run_frame(vecs[i].tx, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));

        // Randomized single-word frames against the reference rule
        for (int k = 0; k < 20; k++) begin
            t = DW'($urandom);
            m = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(t, m, ref_rx(t, m), $sformatf("rnd%0d", k));
        end

        // Two-word frame, second word started from WAIT
        miso_mode = 0;
        clear_mon();
        send_word(16'h1234, 1'b0, rx, lat);
        check("two_w0_rx", rx, 16'h1234);
        check("two_wait_ready", ready, 1);
        check("two_wait_cs", cs, 0);
        repeat (3) @(negedge clk);
        check("two_wait_sck_idle", sck, 0);
        check("two_wait_mosi_hold", mosi, 0);
        send_word(16'hBEEF, 1'b1, rx, lat);
        check("two_w1_rx", rx, 16'hBEEF);
        check("two_w1_no_setup", lat, LAT_WAIT);
        wait_idle(gap);
        check("two_cs_rises", cs_rise_cnt, 1);
        check("two_rx_valid_pulses", rxv_cnt, 2);
        check("two_sck_rises", sck_rise_cnt, 2 * DW);
        check("two_cs_low_cycles", cs_low_cnt > 2 * FRAME_CS - CS_SETUP - CS_HOLD, 1);

        // start held high for the whole frame, tx_data/last scrambled every cycle
        miso_mode = 0;
        clear_mon();
        start = 1'b1; tx_data = 16'h3C3C; last = 1'b1;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy === 1'b1 && cs === 1'b1) break;
            tx_data = DW'($urandom);
            last    = 1'($urandom);
        end
        start = 1'b0;
        check("pulse_gap_reached", n < 400, 1);
        wait_idle(gap);
        repeat (4) @(negedge clk);
        check("pulse_no_second_frame", busy, 0);
        check("pulse_rx_valid_pulses", rxv_cnt, 1);
        check("pulse_rx", rx_data, 16'h3C3C);
        check("pulse_mosi_order", bus_bits, 16'h3C3C);
        check("pulse_sck_rises", sck_rise_cnt, DW);
        check("pulse_cs_low_cycles", cs_low_cnt, FRAME_CS);

        // Reset in the middle of a word
        miso_mode = 0;
        clear_mon();
        start = 1'b1; tx_data = 16'h1234; last = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 400 && sck_rise_cnt < 8; n++) @(negedge clk);
        check("midrst_reached_bit7", sck_rise_cnt, 8);
        check("midrst_sck_high_before", sck, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_cs", cs, 1);
        check("midrst_sck", sck, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mosi", mosi, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_no_rx_valid", rxv_cnt, 0);
        check("midrst_ready", ready, 1);
        run_frame(16'h00FF, 0, 16'h00FF, "postrst");

        // Register read from the slave model
        miso_mode = 3;
        clear_mon();
        send_word(16'h8005, 1'b0, rx, lat);
        check("slv_cmd_rx", rx, 16'h0000);
        send_word(16'h0000, 1'b1, rx, lat);
        check("slv_reg5_rx", rx, 16'h5EED);
        wait_idle(gap);
        check("slv_cs_rises", cs_rise_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
